conv_seq_ctrl: RTL and testbench

- Sequencer for one convolution pass on the systolic array.
- Replaces hand-driven load strobes with a single start command:
  - streams K×K weights from weight memory into the array;
  - then streams the IMG×IMG input map from input memory;
  - counts result strobes from the array and generates result-memory write addresses;
  - signals completion or timeout.
- Sits between the top-level host/register interface and the array plus its input, weight and result memories.

---
 rtl/conv_seq_pkg.sv | 32 +++
 rtl/conv_seq_ctrl_phase_cnt.sv | 38 +++
 rtl/conv_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and derived sizes for the convolution-pass sequencer.
//   state_t      : sequencer states, 3-bit encoding
//   calc_nw/ni   : number of weights / input pixels for one pass
//   calc_out/nr  : output map edge length / number of results for one pass
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_LOAD = 3'd1,
        GAP    = 3'd2,
        I_LOAD = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic int calc_nw(input int k_size);
        return k_size * k_size;
    endfunction

    function automatic int calc_ni(input int img_size);
        return img_size * img_size;
    endfunction

    function automatic int calc_out(input int img_size, input int k_size);
        return img_size - k_size + 1;
    endfunction

    function automatic int calc_nr(input int img_size, input int k_size);
        return calc_out(img_size, k_size) * calc_out(img_size, k_size);
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_phase_cnt.sv
// Loadable up-counter used for memory-address and result-count sequencing.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (highest priority)
//   ld, ld_val : synchronous load of ld_val
//   en         : count up by one
//   last       : terminal value; tc is high while cnt equals it
//   cnt        : current count
module phase_cnt
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for one convolution pass on the systolic array: on start it
// streams K*K weights, waits GAP_CYC idle cycles, streams IMG*IMG input
// pixels, then collects result strobes until all results are in or the
// array goes quiet for too long.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, abort    : pass request (IDLE only) / synchronous abort to IDLE
//   res_sig         : result-valid strobe from the array
//   w_load, i_load  : weight / input load strobes to the array
//   mem_addr        : shared read address for weight and input memories
//   res_we/res_addr : result-memory write enable and address
//   busy, done, err : status (not idle / completion pulse / timeout flag)
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int IMG_SIZE = 14,
    parameter int K_SIZE   = 3,
    parameter int ADDR_W   = 16,
    parameter int GAP_CYC  = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              res_sig,
    output logic              w_load,
    output logic              i_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NW   = calc_nw(K_SIZE);
    localparam int NI   = calc_ni(IMG_SIZE);
    localparam int NR   = calc_nr(IMG_SIZE, K_SIZE);
    localparam int TO_W = $clog2(TIMEOUT) + 1;

    localparam logic [ADDR_W-1:0] NW_LAST  = ADDR_W'(NW - 1);
    localparam logic [ADDR_W-1:0] NI_LAST  = ADDR_W'(NI - 1);
    localparam logic [ADDR_W-1:0] NR_FULL  = ADDR_W'(NR);
    localparam logic [ADDR_W-1:0] GAP_LAST = (GAP_CYC > 0) ? ADDR_W'(GAP_CYC - 1) : '0;
    // The decision is taken in the cycle whose increment would make the
    // counter reach TIMEOUT-1.
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ph_cnt, ph_last, r_cnt;
    logic              ph_tc, ph_clr, ph_en;
    logic              r_full, r_clr, r_en, capture;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;

    assign capture = (state == I_LOAD) || (state == DRAIN);
    assign to_hit  = (state == DRAIN) && !res_sig && (to_cnt == TO_LAST);

    // Next state; abort overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = W_LOAD;
            W_LOAD:  if (ph_tc) state_nxt = (GAP_CYC > 0) ? GAP : I_LOAD;
            GAP:     if (ph_tc) state_nxt = I_LOAD;
            I_LOAD:  if (ph_tc) state_nxt = DRAIN;
            DRAIN:   if (r_full || to_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase counter: restarts at every state change and also times the gap.
    always_comb begin
        ph_last = '0;
        case (state)
            W_LOAD:  ph_last = NW_LAST;
            GAP:     ph_last = GAP_LAST;
            I_LOAD:  ph_last = NI_LAST;
            default: ph_last = '0;
        endcase
    end

    assign ph_clr = abort || (state == IDLE) || (state_nxt != state);
    assign ph_en  = (state == W_LOAD) || (state == GAP) || (state == I_LOAD);

    phase_cnt #(.ADDR_W(ADDR_W)) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ph_clr),
        .en     (ph_en),
        .ld     (1'b0),
        .ld_val ('0),
        .last   (ph_last),
        .cnt    (ph_cnt),
        .tc     (ph_tc)
    );

    // Result counter saturates at NR so surplus strobes never write.
    assign r_clr = abort || ((state == IDLE) && start);
    assign r_en  = capture && res_sig && !r_full;

    phase_cnt #(.ADDR_W(ADDR_W)) u_result_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (r_clr),
        .en     (r_en),
        .ld     (1'b0),
        .ld_val ('0),
        .last   (NR_FULL),
        .cnt    (r_cnt),
        .tc     (r_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            res_we   <= 1'b0;
            res_addr <= '0;
            err      <= 1'b0;
        end else if (abort) begin
            to_cnt   <= '0;
            res_we   <= 1'b0;
            res_addr <= '0;
        end else begin
            if (state != DRAIN || res_sig) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            res_we <= r_en;
            if (r_en) res_addr <= r_cnt;
            if ((state == IDLE) && start) begin
                err <= 1'b0;
            end else if (to_hit && !r_full) begin
                err <= 1'b1;
            end
        end
    end

    assign w_load   = (state == W_LOAD);
    assign i_load   = (state == I_LOAD);
    assign mem_addr = (w_load || i_load) ? ph_cnt : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        res_sig = 1'b0;
    logic        w_load, i_load, res_we, busy, done, err;
    logic [15:0] mem_addr, res_addr;
    logic        w_load_g0, i_load_g0, res_we_g0, busy_g0, done_g0, err_g0;
    logic [15:0] mem_addr_g0, res_addr_g0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .res_sig(res_sig),
        .w_load(w_load), .i_load(i_load), .mem_addr(mem_addr), .res_we(res_we),
        .res_addr(res_addr), .busy(busy), .done(done), .err(err)
    );

    conv_seq_ctrl #(.GAP_CYC(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .res_sig(res_sig),
        .w_load(w_load_g0), .i_load(i_load_g0), .mem_addr(mem_addr_g0), .res_we(res_we_g0),
        .res_addr(res_addr_g0), .busy(busy_g0), .done(done_g0), .err(err_g0)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int e_w, input int e_i, input int e_mem,
                              input int e_we, input int e_busy, input int e_done, input int e_err);
        check({tag, " w_load"},   int'(w_load),   e_w);
        check({tag, " i_load"},   int'(i_load),   e_i);
        check({tag, " mem_addr"}, int'(mem_addr), e_mem);
        check({tag, " res_we"},   int'(res_we),   e_we);
        check({tag, " busy"},     int'(busy),     e_busy);
        check({tag, " done"},     int'(done),     e_done);
        check({tag, " err"},      int'(err),      e_err);
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w_e, i_e, m_e, we_e, b_e, d_e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset res_addr", int'(res_addr), 0);
        check("reset g0 busy", int'(busy_g0), 0);
        check("reset g0 mem_addr", int'(mem_addr_g0), 0);
        rst_n = 1'b1;
        tick();

        // Full pass: weights, gap, inputs, 145 strobes (last one surplus),
        // plus start re-asserted at cycle 5 and during I_LOAD.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 330; c++) begin
            start   = (c == 5) || (c == 100);
            res_sig = (c >= 180) && (c <= 324);
            w_e  = (c >= 1 && c <= 9) ? 1 : 0;
            i_e  = (c >= 12 && c <= 207) ? 1 : 0;
            m_e  = (w_e == 1) ? c - 1 : ((i_e == 1) ? c - 12 : 0);
            we_e = (c >= 181 && c <= 324) ? 1 : 0;
            b_e  = (c <= 325) ? 1 : 0;
            d_e  = (c == 325) ? 1 : 0;
            check_outs("pass", w_e, i_e, m_e, we_e, b_e, d_e, 0);
            if (we_e == 1) check("pass res_addr", int'(res_addr), c - 181);
            if (c == 9) begin
                check("g0 w_load c9", int'(w_load_g0), 1);
                check("g0 mem_addr c9", int'(mem_addr_g0), 8);
            end
            if (c == 10) begin
                check("g0 w_load c10", int'(w_load_g0), 0);
                check("g0 i_load c10", int'(i_load_g0), 1);
                check("g0 mem_addr c10", int'(mem_addr_g0), 0);
            end
            tick();
        end
        start   = 1'b0;
        res_sig = 1'b0;

        // Timeout pass: 100 results in DRAIN, then silence.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 1340; c++) begin
            res_sig = (c >= 210) && (c <= 309);
            check("to done", int'(done), (c == 1333) ? 1 : 0);
            check("to busy", int'(busy), (c <= 1333) ? 1 : 0);
            if (c == 1332) check("to err before", int'(err), 0);
            if (c == 1333) begin
                check("to err", int'(err), 1);
                check("to res_addr", int'(res_addr), 99);
            end
            tick();
        end
        res_sig = 1'b0;
        check("err held in idle", int'(err), 1);

        // Next start clears err; abort inside I_LOAD.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err cleared", int'(err), 0);
        for (int c = 1; c <= 60; c++) begin
            abort   = (c == 50);
            res_sig = (c == 50);
            if (c <= 49) check("ab busy", int'(busy), 1);
            if (c == 50) begin
                check("ab i_load c50", int'(i_load), 1);
                check("ab mem_addr c50", int'(mem_addr), 38);
            end
            if (c >= 51) check_outs("ab idle", 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        abort   = 1'b0;
        res_sig = 1'b0;

        // Fresh start replays weights from address 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check("re w_load", int'(w_load), 1);
            check("re mem_addr", int'(mem_addr), c - 1);
            tick();
        end
        check_outs("re gap", 0, 0, 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of GAP.
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async rst", 0, 0, 0, 0, 0, 0, 0);
        check("async rst res_addr", int'(res_addr), 0);
        check("async rst g0 busy", int'(busy_g0), 0);
        check("async rst g0 i_load", int'(i_load_g0), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("post rst busy", int'(busy), 0);
        check("post rst done", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
